// File: rtl/div_seq_if.sv
// div_seq_if: start/done handshake and operand/result bundle for div_seq
interface div_seq_if #(parameter int N = 32);
  logic         start;
  logic         signed_op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring divider, N+2 cycle latency, RISC-V DIV/REM semantics
module div_seq #(parameter int N = 32) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t       state;
  logic [N:0]   rem;
  logic [N-1:0] q;
  logic [N-1:0] dvs;
  logic [CW-1:0] cnt;
  logic         neg_q, neg_r, dz;
  logic         a_neg, b_neg;
  logic [N:0]   sh, diff;
  always_comb begin
    a_neg = bus.signed_op & bus.dividend[N-1];
    b_neg = bus.signed_op & bus.divisor[N-1];
    sh    = {rem[N-1:0], q[N-1]};
    diff  = sh - {1'b0, dvs};
  end
  // q holds the dividend magnitude and shifts quotient bits in from the bottom
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rem             <= '0;
      q               <= '0;
      dvs             <= '0;
      cnt             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dz              <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= bus.start;
          if (bus.start) begin
            q     <= a_neg ? -bus.dividend : bus.dividend;
            dvs   <= b_neg ? -bus.divisor : bus.divisor;
            rem   <= '0;
            cnt   <= CW'(N - 1);
            dz    <= bus.divisor == '0;
            neg_q <= (a_neg ^ b_neg) & (bus.divisor != '0);
            neg_r <= a_neg;
            state <= RUN;
          end
        end
        RUN: begin
          rem   <= diff[N] ? sh : diff;
          q     <= {q[N-2:0], ~diff[N]};
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? FIX : RUN;
        end
        FIX: begin
          // negating the remainder magnitude restores the original dividend on divide by zero
          bus.quotient    <= dz ? '1 : (neg_q ? -q : q);
          bus.remainder   <= neg_r ? -rem[N-1:0] : rem[N-1:0];
          bus.div_by_zero <= dz;
          bus.done        <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/div_seq.md
# div_seq

Parametrised sequential integer divider: a multi-cycle radix-2 restoring divider with a start/done handshake, selectable signed or unsigned mode, and defined divide-by-zero results. It is the next-generation divider for the core's arithmetic datapath, intended for CPU M-extension and DSP control paths that can tolerate a fixed N+2 cycle latency in exchange for small area. Results follow RISC-V DIV/DIVU/REM/REMU semantics.

## Interface

- `N`, default 32: operand and result width in bits; must be 2 or greater.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a division; sampled only while idle.
- `signed_op` input 1: 1 = two's-complement division, 0 = unsigned; sampled with `start`.
- `dividend` input N: numerator; sampled with `start`.
- `divisor` input N: denominator; sampled with `start`.
- `busy` output 1: high from the cycle after acceptance until `done`, inclusive.
- `done` output 1: single-cycle pulse; results are valid from this cycle on.
- `quotient` output N: result, held until the next `done`.
- `remainder` output N: result, held until the next `done`.
- `div_by_zero` output 1: flag for the last result, held with the results.

## Operation

- States: IDLE, RUN, FIX.
- **IDLE**
  - `start`=1 latches the operands and the mode, and loads the iteration counter with N-1.
  - Signed mode stores the magnitudes and records `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
  - Next state is RUN.
- **RUN**
  - Each cycle shifts the (N+1)-bit partial remainder left by one and brings in the next dividend MSB.
  - It then trial-subtracts the divisor magnitude. If the result is non-negative, that value is kept and quotient bit = 1; otherwise the partial remainder is restored and quotient bit = 0.
  - The counter decrements each cycle. After exactly N RUN cycles the next state is FIX.
- **FIX**
  - Applies the sign correction: quotient is negated if `neg_q`, remainder is negated if `neg_r`. Unsigned mode applies no correction.
  - Writes `quotient`, `remainder` and `div_by_zero`, pulses `done`, and returns to IDLE.
- Arithmetic and width rules:
  - Magnitudes are N-bit unsigned; the magnitude of -2^(N-1) is 2^(N-1), which fits.
  - The internal remainder path is N+1 bits wide to hold the trial-subtraction borrow.
- Divide by zero (divisor == 0, either mode):
  - `quotient` = all ones, `remainder` = original dividend, `div_by_zero` = 1.
  - No sign correction is applied, and the latency is unchanged (the constant-latency rule still holds).
- Signed overflow (-2^(N-1) / -1):
  - Falls out of the normal datapath with no special case: `quotient` = -2^(N-1), `remainder` = 0, `div_by_zero` = 0.
- `start` while busy is ignored; there is no queueing and no error.
- `start` in the same cycle as `done` is ignored; the earliest accepted restart is the cycle after `done`.
- Operand inputs may change freely after acceptance.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately: no `done` is produced, and the outputs return to their reset values.
- Latency: `start` sampled at edge k gives `busy`=1 after edge k, RUN over edges k+1 to k+N, FIX at edge k+N+1, and `done`=1 for one cycle after edge k+N+1.
- Total latency is N+1 edges, i.e. N+2 cycles counting the request cycle. It is fixed and independent of operand values and mode.
- `busy` falls on the same edge that `done` falls.
- Maximum throughput is one division per N+2 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan

All scenarios use N=8.

- **Unsigned basic:** unsigned 10 / 3 -> `quotient`=3, `remainder`=1, `div_by_zero`=0. `done` appears exactly 9 edges after the `start` edge. Repeat with 200 / 7 -> `quotient`=28, `remainder`=4.
- **Signed rounding and signs:** signed 0xF9 / 0x02 (-7 / 2) -> `quotient`=0xFD (-3), `remainder`=0xFF (-1). Signed 0x07 / 0xFE (7 / -2) -> `quotient`=0xFD, `remainder`=0x01. Same-value unsigned 0xF9 / 0x02 -> `quotient`=0x7C, `remainder`=0x01.
- **Corner cases:** 0x2A / 0x00 in both modes -> `quotient`=0xFF, `remainder`=0x2A, `div_by_zero`=1, at the normal latency. Signed 0x80 / 0xFF -> `quotient`=0x80, `remainder`=0x00, `div_by_zero`=0.
- **Handshake:**
  - Hold `start` high continuously with changing operands.
  - Only the operands present at each IDLE acceptance are used.
  - Re-acceptance happens on the cycle after `done`.
  - Exactly one `done` per accepted operation, and `busy` is never low during RUN or FIX.
- **Reset mid-operation:** pulse `rst` asynchronously (between edges) during RUN -> all outputs 0 immediately and no `done`. A following 10 / 3 completes correctly at full latency.
- **Random sweep:** at least 10k random operands in both modes, checked against a reference model (RISC-V semantics). Results are held stable between `done` pulses.
